// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared encodings for the RAM responder
// Purpose: access-size codes, OpCode bit positions and FSM state encoding.
// Ports: none (package).
package ram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam int OP_SIZE_LSB  = 0;
  localparam int OP_SIGN_BIT  = 2;
  localparam int OP_WRITE_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_byte_array.sv
// rtl/ram_byte_array.sv - big-endian byte storage with 4-lane write port
// Purpose: holds Mem (never reset); one aligned 32-bit word per access.
// Ports: clk; word_idx selects the aligned word; wr_be[3] is the lane at
// byte offset 0 (bits 31:24), wr_be[0] offset 3; rd_data is the whole word.
module ram_byte_array #(
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-3:0] word_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [7:0] Mem [DEPTH];

  // Plain always: the bench preloads Mem hierarchically before reset release.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (wr_be[j]) begin
        Mem[{word_idx, 2'(3 - j)}] <= wr_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < 4; j++) begin
      rd_data[8*j +: 8] = Mem[{word_idx, 2'(3 - j)}];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - byte-addressed RAM responder with wait states and fault reporting
// Purpose: IDLE/BUSY/DONE handshake with the control unit, alignment check,
// lane steering for writes and zero/sign extension for reads.
// Ports: Clk, RESET (async, active-high); RAM_enable, RAM_OpCode, Address,
// DataIn request side; DataOut, MFC, MSET response side (zero outside DONE).
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        MSET
);

  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   dout_q, dout_d;
  logic          mfc_q, mfc_d;
  logic          mset_q, mset_d;

  logic [1:0]    size;
  logic          sign_ext;
  logic          is_write;
  logic          fault;
  logic          do_access;
  logic [3:0]    lane_be;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_value;

  // OpCode[5:4] and address bits above the array size are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{RAM_OpCode[5:4], Address[31:AW]};

  ram_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk      (Clk),
    .word_idx (addr_q[AW-1:2]),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_data  (rd_data)
  );

  always_comb begin
    size     = op_q[OP_SIZE_LSB +: 2];
    sign_ext = op_q[OP_SIGN_BIT];
    is_write = op_q[OP_WRITE_BIT];
    fault    = (size == SIZE_ILLEGAL)
            || (size == SIZE_HALF && addr_q[0])
            || (size == SIZE_WORD && addr_q[1:0] != 2'b00);
    // Bring the addressed byte/halfword to the top of the word (big-endian).
    rd_shift = rd_data << {addr_q[1:0], 3'b000};
    lane_be  = 4'b0000;
    wr_data  = din_q;
    rd_value = '0;
    case (size)
      SIZE_BYTE: begin
        lane_be  = 4'b1000 >> addr_q[1:0];
        wr_data  = {4{din_q[7:0]}};
        rd_value = {{24{sign_ext & rd_shift[31]}}, rd_shift[31:24]};
      end
      SIZE_HALF: begin
        lane_be  = addr_q[1] ? 4'b0011 : 4'b1100;
        wr_data  = {2{din_q[15:0]}};
        rd_value = {{16{sign_ext & rd_shift[31]}}, rd_shift[31:16]};
      end
      SIZE_WORD: begin
        lane_be  = 4'b1111;
        rd_value = rd_data;
      end
      default: ;
    endcase
    do_access = (state_q == ST_BUSY) && RAM_enable && (cnt_q == 4'd0);
    wr_be     = (do_access && is_write && !fault) ? lane_be : 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mset_d  = mset_q;
    case (state_q)
      ST_IDLE: begin
        if (RAM_enable) begin
          state_d = ST_BUSY;
          cnt_d   = 4'(WAIT_CYCLES);
          op_d    = RAM_OpCode[3:0];
          addr_d  = Address[AW-1:0];
          din_d   = DataIn;
        end
      end
      ST_BUSY: begin
        if (!RAM_enable) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          mset_d  = fault;
          dout_d  = (fault || is_write) ? 32'd0 : rd_value;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!RAM_enable) begin
          state_d = ST_IDLE;
          mfc_d   = 1'b0;
          mset_d  = 1'b0;
          dout_d  = 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        mfc_d   = 1'b0;
        mset_d  = 1'b0;
        dout_d  = 32'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      mfc_q   <= 1'b0;
      mset_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mset_q  <= mset_d;
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign MSET    = mset_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - randomized self-checking bench for ram_responder
module tb_ram_responder;

  localparam int DEPTH = 512;
  localparam int WAITC = 2;
  localparam int LAT   = WAITC + 2;

  logic        Clk;
  logic        RESET;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
  logic        MSET;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mm [DEPTH];
  logic        exp_mfc;
  logic        exp_mset;
  logic [31:0] exp_dout;

  ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .Clk        (Clk),
    .RESET      (RESET),
    .RAM_enable (RAM_enable),
    .RAM_OpCode (RAM_OpCode),
    .Address    (Address),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .MFC        (MFC),
    .MSET       (MSET)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("cyc_mfc", {31'd0, MFC}, {31'd0, exp_mfc});
    check("cyc_mset", {31'd0, MSET}, {31'd0, exp_mset});
    check("cyc_dout", DataOut, exp_dout);
  end

  // Reference: byte array with big-endian multi-byte accesses.
  task automatic model_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                              output logic f, output logic [31:0] r);
    int n;
    int base;
    logic [31:0] v;
    n    = 1 << op[1:0];
    base = int'(a % 32'(DEPTH));
    f    = (op[1:0] == 2'b11) || ((a % 32'(n)) != 0);
    r    = 32'd0;
    if (!f) begin
      if (op[3]) begin
        for (int i = 0; i < n; i++) mm[(base + i) % DEPTH] = d[8*(n-1-i) +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mm[(base + i) % DEPTH]};
        if (op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r = v;
      end
    end
  endtask

  // Called at posedge+#1. abort_k/reset_k (1..LAT-1) act after that edge; 0 = none.
  task automatic run_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                            input int abort_k, input int reset_k, input int hold,
                            output logic [31:0] got_dout, output logic got_mset, output int mfc_edge);
    logic f;
    logic [31:0] r;
    bit aborted;
    got_dout = 32'd0;
    got_mset = 1'b0;
    mfc_edge = -1;
    aborted  = 0;
    RAM_OpCode = op; Address = a; DataIn = d; RAM_enable = 1'b1;
    for (int k = 1; k <= LAT + hold; k++) begin
      @(posedge Clk); #1;
      if (MFC && mfc_edge < 0) mfc_edge = k;
      if (k == abort_k) begin
        RAM_enable = 1'b0;
        aborted = 1;
        break;
      end
      if (k == reset_k) begin
        RESET = 1'b1;
        aborted = 1;
        break;
      end
      if (k == LAT) begin
        model_access(op, a, d, f, r);
        exp_mfc = 1'b1; exp_mset = f; exp_dout = r;
        got_dout = DataOut; got_mset = MSET;
      end
      if (k > LAT) begin
        Address = $urandom; DataIn = $urandom; RAM_OpCode = 6'($urandom);
      end
    end
    if (aborted) begin
      @(posedge Clk); #1;
      if (MFC && mfc_edge < 0) mfc_edge = 99;
      RESET = 1'b0;
      RAM_enable = 1'b0;
    end else begin
      RAM_enable = 1'b0;
      @(posedge Clk); #1;
      exp_mfc = 1'b0; exp_mset = 1'b0; exp_dout = 32'd0;
    end
  endtask

  logic [31:0] gd;
  logic        gm;
  int          me;
  logic [31:0] pre;

  initial begin
    RESET = 1'b1; RAM_enable = 1'b0; RAM_OpCode = 6'd0; Address = 32'd0; DataIn = 32'd0;
    exp_mfc = 1'b0; exp_mset = 1'b0; exp_dout = 32'd0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'($urandom);
    mm[0] = 8'h8A; mm[1] = 8'h00; mm[2] = 8'h00; mm[3] = 8'h01;
    mm[4] = 8'h11; mm[5] = 8'h22; mm[6] = 8'h33; mm[7] = 8'h44;
    for (int i = 0; i < DEPTH; i++) dut.u_mem.Mem[i] = mm[i];
    repeat (3) @(posedge Clk);
    #1;
    check("reset_mfc", {31'd0, MFC}, 32'd0);
    check("reset_mset", {31'd0, MSET}, 32'd0);
    check("reset_dout", DataOut, 32'd0);
    RESET = 1'b0;
    @(posedge Clk); #1;

    // Word read with latency
    run_access(6'b000010, 32'd0, 32'd0, 0, 0, 2, gd, gm, me);
    check("word_read_data", gd, 32'h8A00_0001);
    check("word_read_mset", {31'd0, gm}, 32'd0);
    check("word_read_latency", me, 4);

    // Signed and unsigned byte reads
    run_access(6'b000100, 32'd0, 32'd0, 0, 0, 1, gd, gm, me);
    check("sbyte_read", gd, 32'hFFFF_FF8A);
    run_access(6'b000000, 32'd0, 32'd0, 0, 0, 0, gd, gm, me);
    check("ubyte_read", gd, 32'h0000_008A);

    // Halfword write then word read
    run_access(6'b001001, 32'd6, 32'h0000_BEEF, 0, 0, 1, gd, gm, me);
    check("half_write_dout", gd, 32'd0);
    check("half_write_mset", {31'd0, gm}, 32'd0);
    run_access(6'b000010, 32'd4, 32'd0, 0, 0, 0, gd, gm, me);
    check("half_write_readback", gd, 32'h1122_BEEF);

    // Misaligned word write
    run_access(6'b001010, 32'd2, 32'hDEAD_BEEF, 0, 0, 1, gd, gm, me);
    check("misalign_mset", {31'd0, gm}, 32'd1);
    check("misalign_dout", gd, 32'd0);
    check("misalign_mem", {dut.u_mem.Mem[0], dut.u_mem.Mem[1], dut.u_mem.Mem[2], dut.u_mem.Mem[3]},
          32'h8A00_0001);

    // Abort by enable drop
    pre = {mm[8], mm[9], mm[10], mm[11]};
    run_access(6'b001010, 32'd8, 32'h1234_5678, 2, 0, 0, gd, gm, me);
    check("abort_no_mfc", me, -1);
    check("abort_mem", {dut.u_mem.Mem[8], dut.u_mem.Mem[9], dut.u_mem.Mem[10], dut.u_mem.Mem[11]}, pre);

    // Abort by reset
    pre = {mm[12], mm[13], mm[14], mm[15]};
    run_access(6'b001010, 32'd12, ~pre, 0, 2, 0, gd, gm, me);
    check("rst_abort_no_mfc", me, -1);
    check("rst_abort_mem", {dut.u_mem.Mem[12], dut.u_mem.Mem[13], dut.u_mem.Mem[14], dut.u_mem.Mem[15]}, pre);

    // Wrap-around
    run_access(6'b000010, 32'h0000_0204, 32'd0, 0, 0, 0, gd, gm, me);
    check("wrap_read", gd, 32'h1122_BEEF);
    run_access(6'b110010, 32'hFFFF_FE04, 32'd0, 0, 0, 0, gd, gm, me);
    check("wrap_high_bits", gd, 32'h1122_BEEF);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int mode;
      logic [31:0] a;
      mode = $urandom_range(0, 19);
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31));
      run_access(6'($urandom), a, $urandom,
                 (mode < 2) ? $urandom_range(1, LAT - 1) : 0,
                 (mode == 2) ? $urandom_range(1, LAT - 1) : 0,
                 $urandom_range(0, 3), gd, gm, me);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clk); #1;
      end
    end

    for (int i = 0; i < DEPTH; i++) check("mem_final", {24'd0, dut.u_mem.Mem[i]}, {24'd0, mm[i]});

    @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
